// File: rtl/corr_pair_sequencer_if.sv
// Bus between the pair sequencer, the capture unit (start/cap_ready) and the DUT wrapper input.
// sim_idx carries one extra bit so the final pair count N_VALS**2 fits.
interface corr_pair_sequencer_if #(
  parameter int IN_SIZE = 4,
  parameter int N_VALS  = 16
);
  localparam int SW = 2 * $clog2(N_VALS) + 1;

  logic               start;
  logic               cap_ready;
  logic [IN_SIZE-1:0] in_o;
  logic               trig_begin;
  logic               trig_end;
  logic [SW-1:0]      sim_idx;
  logic               busy;
  logic               done;

  modport master (
    input  start, cap_ready,
    output in_o, trig_begin, trig_end, sim_idx, busy, done
  );

  modport slave (
    output start, cap_ready,
    input  in_o, trig_begin, trig_end, sim_idx, busy, done
  );
endinterface

// File: rtl/corr_pair_sequencer.sv
// Walks every ordered operand pair (i,j), driving i then j onto in_o with trigger pulses.
// Optional macro SEQ_SKIP_DIAG_EN: skip pairs with i==j.
module corr_pair_sequencer #(
  parameter int IN_SIZE = 4,
  parameter int N_VALS  = 16,
  parameter int HOLD    = 1,
  parameter int SETTLE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  corr_pair_sequencer_if.master  bus,
  output logic [2:0]             state_dbg
);
  localparam int IW   = $clog2(N_VALS);
  localparam int SW   = 2 * IW + 1;
  localparam int CMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam bit HAS_GAP = (SETTLE > 0);
  localparam logic [IW-1:0] VMAX      = IW'(N_VALS - 1);
  localparam logic [CW-1:0] HOLD_M1   = CW'(HOLD - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
`ifdef SEQ_SKIP_DIAG_EN
  localparam logic [IW-1:0] FIRST_J = IW'(1);
  localparam logic [IW-1:0] LAST_J  = IW'(N_VALS - 2);
`else
  localparam logic [IW-1:0] FIRST_J = '0;
  localparam logic [IW-1:0] LAST_J  = VMAX;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    APPLY_A  = 3'd2,
    APPLY_B  = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state;
  logic [IW-1:0]      i, j;
  logic [IW-1:0]      nxt_i, nxt_j;
  logic [CW-1:0]      cnt;
  logic               last_pair, last_r;
  logic [IN_SIZE-1:0] in_r;
  logic               tb_r, te_r, busy_r, done_r;
  logic [SW-1:0]      idx_r;

  // Handshake: a pair starts only when cap_ready is high while in WAIT_RDY;
  // once started the pair runs to completion regardless of cap_ready.
  always_comb begin
    nxt_i = i;
    nxt_j = j;
    if (j == VMAX) begin
      nxt_j = '0;
      nxt_i = i + 1'b1;
    end else begin
      nxt_j = j + 1'b1;
    end
`ifdef SEQ_SKIP_DIAG_EN
    if (nxt_i == nxt_j) begin
      if (nxt_j == VMAX) begin
        nxt_j = '0;
        nxt_i = nxt_i + 1'b1;
      end else begin
        nxt_j = nxt_j + 1'b1;
      end
    end
`endif
    last_pair = (i == VMAX) && (j == LAST_J);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      cnt    <= '0;
      last_r <= 1'b0;
      in_r   <= '0;
      tb_r   <= 1'b0;
      te_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      idx_r  <= '0;
    end else begin
      tb_r <= 1'b0;
      te_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            j      <= FIRST_J;
            busy_r <= 1'b1;
            state  <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (bus.cap_ready) begin
            in_r  <= IN_SIZE'(i);
            cnt   <= '0;
            state <= APPLY_A;
          end
        end
        APPLY_A: begin
          if (cnt == HOLD_M1) begin
            in_r  <= IN_SIZE'(j);
            tb_r  <= 1'b1;
            cnt   <= '0;
            state <= APPLY_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        APPLY_B: begin
          if (cnt == HOLD_M1) begin
            te_r   <= 1'b1;
            idx_r  <= idx_r + 1'b1;
            cnt    <= '0;
            last_r <= last_pair;
            if (!last_pair) begin
              i <= nxt_i;
              j <= nxt_j;
            end
            if (HAS_GAP) begin
              state <= GAP;
            end else if (last_pair) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              state <= WAIT_RDY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == SETTLE_M1) begin
            cnt <= '0;
            if (last_r) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              state <= WAIT_RDY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            i      <= '0;
            j      <= FIRST_J;
            idx_r  <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b1;
            state  <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_o       = in_r;
  assign bus.trig_begin = tb_r;
  assign bus.trig_end   = te_r;
  assign bus.sim_idx    = idx_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign state_dbg      = state;
endmodule

// File: tb/tb_corr_pair_sequencer.sv
// Bench for corr_pair_sequencer: dut0 (HOLD=1, SETTLE=0) and dut1 (HOLD=3, SETTLE=2), N_VALS=4.
module tb_corr_pair_sequencer;
  localparam int N = 4;
`ifdef SEQ_SKIP_DIAG_EN
  localparam int TOTAL = N * (N - 1);
  localparam int LJ = N - 2;
  localparam int J0 = 1, J1 = 2, J2 = 3;
`else
  localparam int TOTAL = N * N;
  localparam int LJ = N - 1;
  localparam int J0 = 0, J1 = 1, J2 = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st0, st1;
  int checks = 0;
  int failures = 0;

  corr_pair_sequencer_if #(.IN_SIZE(4), .N_VALS(N)) bus0();
  corr_pair_sequencer_if #(.IN_SIZE(4), .N_VALS(N)) bus1();

  corr_pair_sequencer #(.IN_SIZE(4), .N_VALS(N), .HOLD(1), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
  corr_pair_sequencer #(.IN_SIZE(4), .N_VALS(N), .HOLD(3), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));

  always #5 clk = ~clk;

  // Scoreboard state: expected {i,j} per pair, in order.
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int exp_idx0 = 0;
  int exp_idx1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_pairs(input bit to1);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
`ifdef SEQ_SKIP_DIAG_EN
        if (a == b) continue;
`endif
        if (to1) exp_q1.push_back({4'(a), 4'(b)});
        else exp_q0.push_back({4'(a), 4'(b)});
      end
  endtask

  // dut0 monitor: i is on the bus the cycle before trig_begin, j on it.
  logic [3:0] prev_in0 = '0;
  logic [7:0] e0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.trig_begin) begin
        if (exp_q0.size() == 0) check("pair0_unexpected", 32'd1, 32'd0);
        else begin
          e0 = exp_q0.pop_front();
          check("pair0_i", 32'(prev_in0), 32'(e0[7:4]));
          check("pair0_j", 32'(bus0.in_o), 32'(e0[3:0]));
        end
      end
      if (bus0.trig_end) begin
        exp_idx0++;
        check("idx0", 32'(bus0.sim_idx), 32'(exp_idx0));
      end
    end
    prev_in0 = bus0.in_o;
  end

  // dut1 monitor: i held 3 cycles before trig_begin, 9-cycle period, trig_end 3 after trig_begin.
  logic [3:0] h1[4];
  logic [7:0] e1;
  int cyc1 = 0;
  int last_tb1 = -1;
  always @(negedge clk) begin
    cyc1++;
    h1[3] = h1[2]; h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = bus1.in_o;
    if (!rst) begin
      if (bus1.trig_begin) begin
        if (exp_q1.size() == 0) check("pair1_unexpected", 32'd1, 32'd0);
        else begin
          e1 = exp_q1.pop_front();
          check("pair1_i_load", 32'(h1[3]), 32'(e1[7:4]));
          check("pair1_i_hold", 32'(h1[1]), 32'(e1[7:4]));
          check("pair1_j", 32'(h1[0]), 32'(e1[3:0]));
        end
        if (last_tb1 >= 0) check("period1", 32'(cyc1 - last_tb1), 32'd9);
        last_tb1 = cyc1;
      end
      if (bus1.trig_end) begin
        exp_idx1++;
        check("te_after_tb1", 32'(cyc1 - last_tb1), 32'd3);
        check("idx1", 32'(bus1.sim_idx), 32'(exp_idx1));
      end
    end
  end

  typedef struct {
    logic       start;
    logic       cap_ready;
    logic [3:0] in_o;
    logic       tb;
    logic       te;
    logic [4:0] idx;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(int s, int c, int io, int tb, int te, int idx, int bz);
    vec_t v;
    v.start = s[0]; v.cap_ready = c[0]; v.in_o = io[3:0];
    v.tb = tb[0]; v.te = te[0]; v.idx = idx[4:0]; v.busy = bz[0];
    return v;
  endfunction

  task automatic wait_done(input bit which, input int budget);
    int n = 0;
    while (!(which ? bus1.done : bus0.done) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(which ? "done1_timeout" : "done0_timeout", 32'(which ? bus1.done : bus0.done), 32'd1);
  endtask

  vec_t vt[15];
  int tbs;

  initial begin
    bus0.start = 1'b0; bus0.cap_ready = 1'b1;
    bus1.start = 1'b0; bus1.cap_ready = 1'b1;
    vt[0]  = mk(1, 1, 0,  0, 0, 0, 1);
    vt[1]  = mk(0, 1, 0,  0, 0, 0, 1);
    vt[2]  = mk(0, 1, J0, 1, 0, 0, 1);
    vt[3]  = mk(0, 1, J0, 0, 1, 1, 1);
    vt[4]  = mk(0, 1, 0,  0, 0, 1, 1);
    vt[5]  = mk(0, 1, J1, 1, 0, 1, 1);
    vt[6]  = mk(0, 1, J1, 0, 1, 2, 1);
    for (int k = 7; k < 12; k++) vt[k] = mk(0, 0, J1, 0, 0, 2, 1);
    vt[12] = mk(0, 1, 0,  0, 0, 2, 1);
    vt[13] = mk(0, 1, J2, 1, 0, 2, 1);
    vt[14] = mk(0, 1, J2, 0, 1, 3, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_o", 32'(bus0.in_o), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_idx", 32'(bus0.sim_idx), 32'd0);
    check("rst_state", 32'(st0), 32'd0);
    rst = 1'b0;

    push_pairs(1'b0);
    push_pairs(1'b1);
    for (int k = 0; k < 15; k++) begin
      bus0.start = vt[k].start;
      bus0.cap_ready = vt[k].cap_ready;
      bus1.start = (k == 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_in_o", k), 32'(bus0.in_o), 32'(vt[k].in_o));
      check($sformatf("vec%0d_tb", k), 32'(bus0.trig_begin), 32'(vt[k].tb));
      check($sformatf("vec%0d_te", k), 32'(bus0.trig_end), 32'(vt[k].te));
      check($sformatf("vec%0d_idx", k), 32'(bus0.sim_idx), 32'(vt[k].idx));
      check($sformatf("vec%0d_busy", k), 32'(bus0.busy), 32'(vt[k].busy));
    end

    // start while busy must not restart the run
    bus0.start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("busy_start_ignored", 32'(bus0.busy), 32'd1);
    end
    bus0.start = 1'b0;

    wait_done(1'b0, 200);
    check("done0_idx", 32'(bus0.sim_idx), 32'(TOTAL));
    check("done0_busy", 32'(bus0.busy), 32'd0);
    check("done0_last_j", 32'(bus0.in_o), 32'(LJ));
    check("done0_state", 32'(st0), 32'd5);
    check("done0_q_empty", 32'(exp_q0.size()), 32'd0);

    wait_done(1'b1, 400);
    check("done1_idx", 32'(bus1.sim_idx), 32'(TOTAL));
    check("done1_q_empty", 32'(exp_q1.size()), 32'd0);

    // restart from DONE
    exp_idx0 = 0;
    push_pairs(1'b0);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    check("restart_done", 32'(bus0.done), 32'd0);
    check("restart_idx", 32'(bus0.sim_idx), 32'd0);
    check("restart_busy", 32'(bus0.busy), 32'd1);

    // reset on the cycle after trig_begin of pair 5
    tbs = 0;
    for (int n = 0; n < 100 && tbs < 6; n++) begin
      @(posedge clk); #1;
      if (bus0.trig_begin) tbs++;
    end
    check("pair5_reached", 32'(tbs), 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_te", 32'(bus0.trig_end), 32'd0);
    check("midrst_in_o", 32'(bus0.in_o), 32'd0);
    check("midrst_idx", 32'(bus0.sim_idx), 32'd0);
    check("midrst_busy", 32'(bus0.busy), 32'd0);
    check("midrst_done", 32'(bus0.done), 32'd0);
    check("midrst_state", 32'(st0), 32'd0);
    rst = 1'b0;
    exp_q0.delete();
    exp_idx0 = 0;

    push_pairs(1'b0);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    wait_done(1'b0, 200);
    check("rerun_idx", 32'(bus0.sim_idx), 32'(TOTAL));
    check("rerun_q_empty", 32'(exp_q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
